// File: rtl/control_r_if.sv
// Handshake bundle between the PHY RX stream, control_r and its two RX consumers.
// master = environment side (PHY and consumers), slave = control_r.
interface control_r_if;
    logic       rx_lp_sop;
    logic       rx_lp_eop;
    logic       rx_lp_valid;
    logic       rx_lp_ready;
    logic [7:0] rx_lp_data;
    logic       rx_lp_error;
    logic       rx_to_sop;
    logic       rx_to_eop;
    logic       rx_to_valid;
    logic       rx_to_ready;
    logic [7:0] rx_to_data;
    logic       rx_to_cancle;
    logic       rx_lt_sop;
    logic       rx_lt_eop;
    logic       rx_lt_valid;
    logic       rx_lt_ready;
    logic [7:0] rx_lt_data;
    logic       rx_lt_cancle;
    logic       rx_data_on;
    logic       rx_pid_err;

    modport master (
        output rx_lp_sop, rx_lp_eop, rx_lp_valid, rx_lp_data, rx_lp_error,
        output rx_to_ready, rx_lt_ready,
        input  rx_lp_ready,
        input  rx_to_sop, rx_to_eop, rx_to_valid, rx_to_data, rx_to_cancle,
        input  rx_lt_sop, rx_lt_eop, rx_lt_valid, rx_lt_data, rx_lt_cancle,
        input  rx_data_on, rx_pid_err
    );

    modport slave (
        input  rx_lp_sop, rx_lp_eop, rx_lp_valid, rx_lp_data, rx_lp_error,
        input  rx_to_ready, rx_lt_ready,
        output rx_lp_ready,
        output rx_to_sop, rx_to_eop, rx_to_valid, rx_to_data, rx_to_cancle,
        output rx_lt_sop, rx_lt_eop, rx_lt_valid, rx_lt_data, rx_lt_cancle,
        output rx_data_on, rx_pid_err
    );
endinterface

// File: rtl/control_r.sv
// control_r: RX packet router, PHY byte stream -> token checker (TO) or link layer (LT).
// Optional PID complement check is enabled by defining CONTROL_R_PID_CHECK_EN.
module control_r (
    input  logic       clk,
    input  logic       rst_n,
    control_r_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TOKEN = 2'd1,
        DATA  = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic DEST_TO = 1'b0;
    localparam logic DEST_LT = 1'b1;

    state_t     state_r;
    logic       ov_r;
    logic       dest_r;
    logic       sop_r;
    logic       eop_r;
    logic [7:0] data_r;
    logic       to_cancel_r;
    logic       lt_cancel_r;
    logic       dest_ready_s;
    logic       lp_ready_s;
    logic       acc_s;
    logic       pid_lt_s;
    logic       pid_bad_s;

`ifdef CONTROL_R_PID_CHECK_EN
    logic pid_err_r;

    // High nibble of a valid PID byte is the bitwise complement of the low nibble.
    function automatic logic pid_bad(input logic [7:0] b);
        return (b[7:4] != ~b[3:0]);
    endfunction
`endif

    // Select the destination ready and form the upstream ready / PID decode.
    always_comb begin
        dest_ready_s = 1'b0;
        lp_ready_s   = 1'b0;
        pid_bad_s    = 1'b0;
        if (dest_r == DEST_LT) begin
            dest_ready_s = bus.rx_lt_ready;
        end else begin
            dest_ready_s = bus.rx_to_ready;
        end
        if (state_r == DROP) begin
            lp_ready_s = 1'b1;
        end else begin
            lp_ready_s = ~ov_r | dest_ready_s;
        end
`ifdef CONTROL_R_PID_CHECK_EN
        pid_bad_s = pid_bad(bus.rx_lp_data);
`else
        pid_bad_s = 1'b0;
`endif
    end

    assign acc_s    = bus.rx_lp_valid & lp_ready_s;
    assign pid_lt_s = (bus.rx_lp_data[1:0] == 2'b11);

    // Packet FSM, single-entry output register and one-cycle abort/error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ov_r        <= 1'b0;
            dest_r      <= DEST_TO;
            sop_r       <= 1'b0;
            eop_r       <= 1'b0;
            data_r      <= 8'h00;
            to_cancel_r <= 1'b0;
            lt_cancel_r <= 1'b0;
`ifdef CONTROL_R_PID_CHECK_EN
            pid_err_r   <= 1'b0;
`endif
        end else begin
            to_cancel_r <= 1'b0;
            lt_cancel_r <= 1'b0;
`ifdef CONTROL_R_PID_CHECK_EN
            pid_err_r   <= 1'b0;
`endif
            if (ov_r && dest_ready_s) begin
                ov_r <= 1'b0;
            end
            if (acc_s) begin
                if (bus.rx_lp_error) begin
                    to_cancel_r <= (state_r == TOKEN);
                    lt_cancel_r <= (state_r == DATA);
                    state_r     <= bus.rx_lp_eop ? IDLE : DROP;
                end else begin
                    case (state_r)
                        IDLE, TOKEN, DATA: begin
                            if (bus.rx_lp_sop) begin
                                // A sop inside a packet aborts the packet in flight.
                                to_cancel_r <= (state_r == TOKEN);
                                lt_cancel_r <= (state_r == DATA);
                                if (pid_bad_s) begin
`ifdef CONTROL_R_PID_CHECK_EN
                                    pid_err_r <= 1'b1;
`endif
                                    state_r <= bus.rx_lp_eop ? IDLE : DROP;
                                end else begin
                                    ov_r    <= 1'b1;
                                    data_r  <= bus.rx_lp_data;
                                    sop_r   <= 1'b1;
                                    eop_r   <= bus.rx_lp_eop;
                                    dest_r  <= pid_lt_s;
                                    state_r <= bus.rx_lp_eop ? IDLE : (pid_lt_s ? DATA : TOKEN);
                                end
                            end else if (state_r != IDLE) begin
                                ov_r   <= 1'b1;
                                data_r <= bus.rx_lp_data;
                                sop_r  <= 1'b0;
                                eop_r  <= bus.rx_lp_eop;
                                if (bus.rx_lp_eop) begin
                                    state_r <= IDLE;
                                end
                            end
                        end
                        DROP: begin
                            if (bus.rx_lp_eop) begin
                                state_r <= IDLE;
                            end
                        end
                        default: state_r <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.rx_lp_ready  = lp_ready_s;
    assign bus.rx_to_valid  = ov_r & (dest_r == DEST_TO);
    assign bus.rx_lt_valid  = ov_r & (dest_r == DEST_LT);
    assign bus.rx_to_sop    = sop_r;
    assign bus.rx_to_eop    = eop_r;
    assign bus.rx_to_data   = data_r;
    assign bus.rx_lt_sop    = sop_r;
    assign bus.rx_lt_eop    = eop_r;
    assign bus.rx_lt_data   = data_r;
    assign bus.rx_to_cancle = to_cancel_r;
    assign bus.rx_lt_cancle = lt_cancel_r;
    assign bus.rx_data_on   = (state_r == DATA) | (ov_r & (dest_r == DEST_LT));
`ifdef CONTROL_R_PID_CHECK_EN
    assign bus.rx_pid_err   = pid_err_r;
`else
    assign bus.rx_pid_err   = 1'b0;
`endif
endmodule

// File: tb/tb_control_r.sv
// Directed self-checking bench for control_r; inputs change and outputs are checked on negedge.
module tb_control_r;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   to_n;
    int   lt_n;
    logic [7:0]  lt_log [0:63];
    logic [16:0] obs;
    logic [16:0] exp_v;

    control_r_if bus ();

    control_r dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ready, to_valid, lt_valid, sop, eop, to_cancel, lt_cancel, data_on, pid_err, data}
    assign obs = {bus.rx_lp_ready, bus.rx_to_valid, bus.rx_lt_valid, bus.rx_to_sop, bus.rx_to_eop,
                  bus.rx_to_cancle, bus.rx_lt_cancle, bus.rx_data_on, bus.rx_pid_err, bus.rx_to_data};

    // Beat monitor: records every completed transfer on both output streams.
    always @(posedge clk) begin
        if (rst_n && bus.rx_to_valid && bus.rx_to_ready) to_n <= to_n + 1;
        if (rst_n && bus.rx_lt_valid && bus.rx_lt_ready) begin
            lt_log[lt_n[5:0]] <= bus.rx_lt_data;
            lt_n <= lt_n + 1;
        end
    end

    function automatic logic [16:0] pk(input logic rdy, tov, ltv, sop, eop, toc, ltc, on, pe,
                                       input logic [7:0] d);
        return {rdy, tov, ltv, sop, eop, toc, ltc, on, pe, d};
    endfunction

    task automatic cyc(input logic s, input logic e, input logic v, input logic [7:0] d, input logic er);
        bus.rx_lp_sop   = s;
        bus.rx_lp_eop   = e;
        bus.rx_lp_valid = v;
        bus.rx_lp_data  = d;
        bus.rx_lp_error = er;
        @(negedge clk);
    endtask

    task automatic test_reset;
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_token;
        int b0;
        b0 = to_n;
        cyc(1'b1, 1'b0, 1'b1, 8'hE1, 1'b0);
        exp_v = pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE1);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL tok_b0 obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 1'b1, 8'h15, 1'b0);
        exp_v = pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h15);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL tok_b1 obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 1'b1, 8'hA8, 1'b0);
        exp_v = pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA8);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL tok_b2 obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA8);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL tok_done obs=%h exp=%h", obs, exp_v); end
        checks++;
        if ({bus.rx_lt_sop, bus.rx_lt_eop, bus.rx_lt_data} !== {1'b0, 1'b1, 8'hA8}) begin
            failures++; $display("FAIL tok_lt_mirror got=%b%b%h exp=01a8", bus.rx_lt_sop, bus.rx_lt_eop, bus.rx_lt_data);
        end
        checks++; if (to_n - b0 !== 3) begin failures++; $display("FAIL tok_beats got=%0d exp=3", to_n - b0); end
    endtask

    task automatic test_ack;
        cyc(1'b1, 1'b1, 1'b1, 8'hD2, 1'b0);
        exp_v = pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hD2);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL ack obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hD2);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL idle_nosop obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_data_stall;
        int b0;
        logic [7:0] ev [0:4];
        ev = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
        b0 = lt_n;
        cyc(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL dat_b0 obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL dat_b2 obs=%h exp=%h", obs, exp_v); end
        bus.rx_lt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
            exp_v = pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
            checks++; if (obs !== exp_v) begin failures++; $display("FAIL dat_stall%0d obs=%h exp=%h", i, obs, exp_v); end
        end
        bus.rx_lt_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL dat_b3 obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 1'b1, 8'h44, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL dat_b4 obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL dat_done obs=%h exp=%h", obs, exp_v); end
        checks++; if (lt_n - b0 !== 5) begin failures++; $display("FAIL dat_beats got=%0d exp=5", lt_n - b0); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (lt_log[(b0 + k) % 64] !== ev[k]) begin
                failures++; $display("FAIL dat_order%0d got=%h exp=%h", k, lt_log[(b0 + k) % 64], ev[k]);
            end
        end
    endtask

    task automatic test_abort;
        cyc(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'hD2, 1'b0);
        exp_v = pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hD2);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL abort_sop obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hD2);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL abort_after obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_error;
        int b0;
        b0 = lt_n;
        cyc(1'b1, 1'b0, 1'b1, 8'h4B, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4B);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_b0 obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'hA3, 1'b1);
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA2);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_cancel obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 1'b1, 8'hA4, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'hE1, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA2);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_drop obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'hE1, 1'b0);
        exp_v = pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE1);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_next_tok obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 1'b1, 8'h15, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h15);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_tok_done obs=%h exp=%h", obs, exp_v); end
        checks++; if (lt_n - b0 !== 3) begin failures++; $display("FAIL err_beats got=%0d exp=3", lt_n - b0); end
    endtask

    task automatic test_pid;
`ifdef CONTROL_R_PID_CHECK_EN
        int t0;
        int l0;
        t0 = to_n;
        l0 = lt_n;
        cyc(1'b1, 1'b0, 1'b1, 8'hC4, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h15);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL pid_err obs=%h exp=%h", obs, exp_v); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, (i == 2), 1'b1, 8'h01 + 8'(i), 1'b0);
            exp_v = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h15);
            checks++; if (obs !== exp_v) begin failures++; $display("FAIL pid_drop%0d obs=%h exp=%h", i, obs, exp_v); end
        end
        checks++;
        if ((to_n != t0) || (lt_n != l0)) begin
            failures++; $display("FAIL pid_beats got=%0d exp=0", (to_n - t0) + (lt_n - l0));
        end
`else
        cyc(1'b1, 1'b0, 1'b1, 8'hC4, 1'b0);
        exp_v = pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC4);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL pid_nochk obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 1'b1, 8'h03, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL pid_nochk_end obs=%h exp=%h", obs, exp_v); end
`endif
    endtask

    task automatic test_reset_mid;
        cyc(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0);
        bus.rx_lt_ready = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        exp_v = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rst_pre obs=%h exp=%h", obs, exp_v); end
        rst_n = 1'b0;
        bus.rx_lp_valid = 1'b0;
        #1;
        exp_v = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rst_async obs=%h exp=%h", obs, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.rx_lt_ready = 1'b1;
        @(negedge clk);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rst_nocancel obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rst_idle obs=%h exp=%h", obs, exp_v); end
        cyc(1'b1, 1'b1, 1'b1, 8'hD2, 1'b0);
        exp_v = pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hD2);
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rst_fresh obs=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        to_n     = 0;
        lt_n     = 0;
        rst_n    = 1'b0;
        bus.rx_lp_sop   = 1'b0;
        bus.rx_lp_eop   = 1'b0;
        bus.rx_lp_valid = 1'b0;
        bus.rx_lp_data  = 8'h00;
        bus.rx_lp_error = 1'b0;
        bus.rx_to_ready = 1'b1;
        bus.rx_lt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_token;
        test_ack;
        test_data_stall;
        test_abort;
        test_error;
        test_pid;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
